// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned N-bit restoring divider.
//   The trial subtraction is the subtract direction of an N-parameterised
//   lookahead adder: an (N+1)-bit add of the shifted partial remainder and
//   the inverted divisor, with carry-in 1. One quotient bit is resolved per
//   clock.
//
// Ports (seq_divider):
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   request, sampled only in IDLE
//   dividend     in   N-bit unsigned dividend, captured on accepted start
//   divisor      in   N-bit unsigned divisor, captured on accepted start
//   busy         out  high while iterating (RUN)
//   done         out  one-cycle pulse, result valid
//   quotient     out  N-bit unsigned quotient
//   remainder    out  N-bit unsigned remainder
//   div_by_zero  out  high with done when the captured divisor was 0
//
// Ports (seq_divider_cla):
//   a_i, b_i     in   W-bit addends
//   cin_i        in   carry in
//   sum_o        out  W-bit sum
//   cout_o       out  carry out of bit W-1

// Kogge-Stone style parallel-prefix lookahead adder.
module seq_divider_cla #(
  parameter int W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);
  localparam int LV = $clog2(W);

  logic [W:0] c;

  // Each level doubles the span of the group generate/propagate terms.
  // Levels live in separate generate scopes so no signal feeds itself.
  for (genvar lv = 0; lv <= LV; lv++) begin : g_lvl
    logic [W-1:0] gg;
    logic [W-1:0] pp;
    if (lv == 0) begin : g_base
      assign gg = a_i & b_i;
      assign pp = a_i ^ b_i;
    end else begin : g_pfx
      localparam int D = 1 << (lv - 1);
      for (genvar i = 0; i < W; i++) begin : g_bit
        if (i >= D) begin : g_comb
          assign gg[i] = g_lvl[lv-1].gg[i] | (g_lvl[lv-1].pp[i] & g_lvl[lv-1].gg[i-D]);
          assign pp[i] = g_lvl[lv-1].pp[i] & g_lvl[lv-1].pp[i-D];
        end else begin : g_pass
          assign gg[i] = g_lvl[lv-1].gg[i];
          assign pp[i] = g_lvl[lv-1].pp[i];
        end
      end
    end
  end

  // Final level holds group terms over bits [i:0]; fold in the carry-in.
  assign c[0] = cin_i;
  for (genvar i = 0; i < W; i++) begin : g_carry
    assign c[i+1] = g_lvl[LV].gg[i] | (g_lvl[LV].pp[i] & cin_i);
  end

  assign sum_o  = g_lvl[0].pp ^ c[W-1:0];
  assign cout_o = c[W];
endmodule

module seq_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [N-1:0]  dvd_q;   // working copy of the dividend, MSB-first shifter
  logic [N-1:0]  dvs_q;
  logic [N-1:0]  rem_q;
  logic [N-1:0]  quo_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          dbz_q;

  logic [N:0]    shifted;
  logic [N:0]    trial;
  logic          no_borrow;
  logic [N-1:0]  rem_d;
  logic [N-1:0]  quo_d;
  logic          unused_trial_msb;

  // Bring the next dividend bit into the partial remainder.
  assign shifted = {rem_q, dvd_q[N-1]};

  // shifted - divisor as shifted + ~{0,divisor} + 1; carry out = no borrow.
  seq_divider_cla #(.W(N + 1)) u_sub (
    .a_i    (shifted),
    .b_i    (~{1'b0, dvs_q}),
    .cin_i  (1'b1),
    .sum_o  (trial),
    .cout_o (no_borrow)
  );

  // Remainder stays below the divisor, so bit N of either candidate is 0.
  assign rem_d            = no_borrow ? trial[N-1:0] : shifted[N-1:0];
  assign quo_d            = {quo_q[N-2:0], no_borrow};
  assign unused_trial_msb = trial[N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            if (divisor != '0) begin
              rem_q   <= '0;
              quo_q   <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              dbz_q   <= 1'b0;
              state_q <= RUN;
            end else begin
              // Divide by zero short-circuits straight to the result.
              quo_q   <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        RUN: begin
          dvd_q <= {dvd_q[N-2:0], 1'b0};
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            dbz_q   <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule
